// File: rtl/rv_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rv_mem_stage                                                  |
// | Description : Memory-access pipeline stage. Registers execute results,      |
// |               runs load/store transactions on a req/ack data bus with       |
// |               byte-lane steering and load extension, and stalls upstream    |
// |               while a transaction is outstanding.                           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module rv_mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_rs2_val,
  input  logic [4:0]  i_rd,
  input  logic [29:0] i_pc_p4,
  input  logic [1:0]  i_res_src,
  input  logic [2:0]  i_funct3,
  input  logic        i_reg_write,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  output logic        o_dbus_req,
  output logic        o_dbus_we,
  output logic [29:0] o_dbus_addr,
  output logic [3:0]  o_dbus_be,
  output logic [31:0] o_dbus_wdata,
  input  logic        i_dbus_ack,
  input  logic [31:0] i_dbus_rdata,
  output logic        o_stall,
  output logic [31:0] o_alu_result,
  output logic [31:0] o_load_data,
  output logic [4:0]  o_rd,
  output logic        o_reg_write,
  output logic [29:0] o_pc_p4,
  output logic [1:0]  o_res_src,
  output logic        o_misaligned,
  output logic        o_bus_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  // Counter only needs to reach TIMEOUT_CYCLES-1 (REQ cycles are counted from 0).
  localparam int          CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [31:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam logic        TO_EN    = (TIMEOUT_CYCLES != 0);

  // Stage registers
  logic [31:0] r_alu_result;
  logic [31:0] r_rs2_val;
  logic [4:0]  r_rd;
  logic [29:0] r_pc_p4;
  logic [1:0]  r_res_src;
  logic [2:0]  r_funct3;
  logic        r_reg_write;
  logic        r_mem_read;
  logic        r_mem_write;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;

  logic        w_stall;
  logic        w_req;
  logic        w_timeout;
  logic        w_in_go;
  logic        w_cur_mis;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;

  // Access size depends on direction: stores treat every funct3 other than
  // SB/SH as a word, loads decode size from funct3[1:0] (bit 2 is the
  // unsigned flag).
  function automatic logic f_misaligned(input logic [2:0] f3, input logic is_store,
                                        input logic [1:0] off);
    logic half;
    logic word;
    if (is_store) begin
      half = (f3 == 3'b001);
      word = (f3 != 3'b000) && (f3 != 3'b001);
    end else begin
      half = (f3[1:0] == 2'b01);
      word = f3[1];
    end
    return (half & off[0]) | (word & (off != 2'b00));
  endfunction

  // Incoming op that will start a bus transaction once captured.
  assign w_in_go = (i_mem_read | i_mem_write) &
                   ~f_misaligned(i_funct3, i_mem_write, i_alu_result[1:0]);

  // Op currently held in the stage is misaligned (never issued to the bus).
  assign w_cur_mis = (r_mem_read | r_mem_write) &
                     f_misaligned(r_funct3, r_mem_write, r_alu_result[1:0]);

  assign w_off = r_alu_result[1:0];

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // Next state, stall, request and timeout decode
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_req        = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall = 1'b0;
      end
      ST_REQ: begin
        w_timeout = TO_EN & ~i_dbus_ack & (32'(r_cnt) == CNT_LAST);
        w_stall   = ~i_dbus_ack & ~w_timeout;
        w_req     = ~w_timeout;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    // Whenever the stage advances, the captured op decides the next state.
    if (!w_stall) w_next_state = w_in_go ? ST_REQ : ST_IDLE;
  end

  // Wait-cycle counter: cleared whenever the stage advances, counts stalled REQ cycles
  always_ff @(posedge i_clk) begin
    if (i_reset)       r_cnt <= '0;
    else if (!w_stall) r_cnt <= '0;
    else               r_cnt <= r_cnt + 1'b1;
  end

  // Stage registers capture the execute results whenever the stage is not stalled
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_alu_result <= '0;
      r_rs2_val    <= '0;
      r_rd         <= '0;
      r_pc_p4      <= '0;
      r_res_src    <= '0;
      r_funct3     <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else if (!w_stall) begin
      r_alu_result <= i_alu_result;
      r_rs2_val    <= i_rs2_val;
      r_rd         <= i_rd;
      r_pc_p4      <= i_pc_p4;
      r_res_src    <= i_res_src;
      r_funct3     <= i_funct3;
      r_reg_write  <= i_reg_write;
      r_mem_read   <= i_mem_read;
      r_mem_write  <= i_mem_write;
    end
  end

  // Store lane steering; loads always fetch the whole word
  always_comb begin
    w_be    = 4'hF;
    w_wdata = r_rs2_val;
    if (r_mem_write) begin
      case (r_funct3)
        3'b000: begin
          w_be    = 4'b0001 << w_off;
          w_wdata = {4{r_rs2_val[7:0]}};
        end
        3'b001: begin
          w_be    = w_off[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{r_rs2_val[15:0]}};
        end
        default: begin
          w_be    = 4'hF;
          w_wdata = r_rs2_val;
        end
      endcase
    end
  end

  // Load byte/half extraction and sign/zero extension
  always_comb begin
    w_byte = i_dbus_rdata[7:0];
    case (w_off)
      2'd0:    w_byte = i_dbus_rdata[7:0];
      2'd1:    w_byte = i_dbus_rdata[15:8];
      2'd2:    w_byte = i_dbus_rdata[23:16];
      default: w_byte = i_dbus_rdata[31:24];
    endcase
    w_half = w_off[1] ? i_dbus_rdata[31:16] : i_dbus_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_ext = {24'h0, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_ext = {16'h0, w_half};
      default: w_load_ext = i_dbus_rdata;
    endcase
  end

  assign o_dbus_req   = w_req;
  assign o_dbus_we    = w_req & r_mem_write;
  assign o_dbus_addr  = r_alu_result[31:2];
  assign o_dbus_be    = w_req ? w_be : 4'h0;
  assign o_dbus_wdata = w_wdata;

  // Read data is only forwarded in the completing cycle so a stray bus value
  // never leaks out while idle or in reset.
  assign o_load_data  = ((r_state == ST_REQ) && i_dbus_ack) ? w_load_ext : 32'h0;

  assign o_stall      = w_stall;
  assign o_alu_result = r_alu_result;
  assign o_rd         = r_rd;
  assign o_pc_p4      = r_pc_p4;
  assign o_res_src    = r_res_src;
  assign o_misaligned = w_cur_mis;
  assign o_bus_err    = w_timeout;
  assign o_reg_write  = r_reg_write & ~w_stall & ~w_cur_mis & ~w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rv_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rv_mem_stage                                               |
// | Description : Self-checking bench for rv_mem_stage with directed scenarios  |
// |               and randomized back-to-back traffic against a reference model.|
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_rv_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_alu_result;
  logic [31:0] i_rs2_val;
  logic [4:0]  i_rd;
  logic [29:0] i_pc_p4;
  logic [1:0]  i_res_src;
  logic [2:0]  i_funct3;
  logic        i_reg_write;
  logic        i_mem_read;
  logic        i_mem_write;
  logic        o_dbus_req;
  logic        o_dbus_we;
  logic [29:0] o_dbus_addr;
  logic [3:0]  o_dbus_be;
  logic [31:0] o_dbus_wdata;
  logic        i_dbus_ack;
  logic [31:0] i_dbus_rdata;
  logic        o_stall;
  logic [31:0] o_alu_result;
  logic [31:0] o_load_data;
  logic [4:0]  o_rd;
  logic        o_reg_write;
  logic [29:0] o_pc_p4;
  logic [1:0]  o_res_src;
  logic        o_misaligned;
  logic        o_bus_err;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  rv_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_alu_result(i_alu_result), .i_rs2_val(i_rs2_val), .i_rd(i_rd),
    .i_pc_p4(i_pc_p4), .i_res_src(i_res_src), .i_funct3(i_funct3),
    .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .o_dbus_req(o_dbus_req), .o_dbus_we(o_dbus_we), .o_dbus_addr(o_dbus_addr),
    .o_dbus_be(o_dbus_be), .o_dbus_wdata(o_dbus_wdata),
    .i_dbus_ack(i_dbus_ack), .i_dbus_rdata(i_dbus_rdata),
    .o_stall(o_stall), .o_alu_result(o_alu_result), .o_load_data(o_load_data),
    .o_rd(o_rd), .o_reg_write(o_reg_write), .o_pc_p4(o_pc_p4),
    .o_res_src(o_res_src), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
  );

  logic [172:0] all_out;
  assign all_out = {o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_be, o_dbus_wdata,
                    o_stall, o_alu_result, o_load_data, o_rd, o_reg_write,
                    o_pc_p4, o_res_src, o_misaligned, o_bus_err};

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [29:0] pc;
    logic [1:0]  rsrc;
    logic [2:0]  f3;
    logic        rw;
    logic        mr;
    logic        mw;
  } op_t;

  // ---------------- reference model (architectural rules) ----------------
  function automatic logic ref_mis(input op_t o);
    int sz;  // access size in bytes
    if (!(o.mr || o.mw)) return 1'b0;
    if (o.mw) sz = (o.f3 == 3'd0) ? 1 : (o.f3 == 3'd1) ? 2 : 4;
    else      sz = ((o.f3 % 4) == 0) ? 1 : ((o.f3 % 4) == 1) ? 2 : 4;
    return (o.addr % sz) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input op_t o);
    int off;
    off = o.addr % 4;
    if (!o.mw) return 4'hF;
    if (o.f3 == 3'd0) return 4'(1 << off);
    if (o.f3 == 3'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input op_t o);
    if (o.f3 == 3'd0) return 32'(o.rs2[7:0]) * 32'h0101_0101;
    if (o.f3 == 3'd1) return 32'(o.rs2[15:0]) * 32'h0001_0001;
    return o.rs2;
  endfunction

  function automatic logic [31:0] ref_load(input op_t o, input logic [31:0] rdata);
    logic [31:0] b;
    logic [31:0] h;
    int off;
    off = o.addr % 4;
    b = (rdata >> (8 * off)) & 32'hFF;
    h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
    case (o.f3)
      3'd0:    return (b >= 32'h80) ? b - 32'h100 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'h8000) ? h - 32'h1_0000 : h;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int kind;
    o = op_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    kind = $urandom_range(0, 2);
    o.mr = (kind == 1);
    o.mw = (kind == 2);
    if (ref_mis(o) && ($urandom_range(0, 3) != 0)) o.addr[1:0] = 2'b00;
    return o;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input op_t o);
    i_alu_result = o.addr;
    i_rs2_val    = o.rs2;
    i_rd         = o.rd;
    i_pc_p4      = o.pc;
    i_res_src    = o.rsrc;
    i_funct3     = o.f3;
    i_reg_write  = o.rw;
    i_mem_read   = o.mr;
    i_mem_write  = o.mw;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic op_t mk(input logic [31:0] addr, input logic [31:0] rs2,
                             input logic [2:0] f3, input logic rw,
                             input logic mr, input logic mw);
    op_t o;
    o = '0;
    o.addr = addr; o.rs2 = rs2; o.f3 = f3; o.rw = rw; o.mr = mr; o.mw = mw;
    o.rd = 5'd9; o.pc = 30'h155; o.rsrc = 2'd1;
    return o;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_reset = 1'b1;
    drive(rand_op());
    i_mem_read = 1'b1;
    i_dbus_ack = 1'b1;
    i_dbus_rdata = $urandom;
    tick();
    tick();
    #1;
    chk_cnt++;
    if (all_out !== '0) $display("FAIL reset_outputs got=%h exp=0", all_out);
    else pass_cnt++;
    i_reset = 1'b0;
    drive('0);
    i_dbus_ack = 1'b0;
    tick();
    #1;
    chk_cnt++;
    if (all_out !== '0) $display("FAIL reset_release got=%h exp=0", all_out);
    else pass_cnt++;
  endtask

  task automatic test_store_word();
    op_t o;
    @(negedge clk);
    o = mk(32'h100, 32'hDEAD_BEEF, 3'b010, 1'b0, 1'b0, 1'b1);
    drive(o);
    i_dbus_ack = 1'b0;
    #1;
    chk_cnt++;
    if (o_stall !== 1'b0) $display("FAIL sw_capture_stall got=%b exp=0", o_stall);
    else pass_cnt++;
    tick();
    i_dbus_ack = 1'b1;
    drive('0);
    #1;
    chk_cnt++;
    if ({o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_be} !== {1'b1, 1'b1, 30'h40, 4'hF})
      $display("FAIL sw_bus got=%h exp=%h", {o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_be},
               {1'b1, 1'b1, 30'h40, 4'hF});
    else pass_cnt++;
    chk_cnt++;
    if ({o_dbus_wdata, o_stall} !== {32'hDEAD_BEEF, 1'b0})
      $display("FAIL sw_wdata_stall got=%h exp=%h", {o_dbus_wdata, o_stall}, {32'hDEAD_BEEF, 1'b0});
    else pass_cnt++;
    tick();
    i_dbus_ack = 1'b0;
    #1;
    chk_cnt++;
    if ({o_dbus_req, o_stall} !== 2'b00) $display("FAIL sw_done got=%b exp=00", {o_dbus_req, o_stall});
    else pass_cnt++;
  endtask

  task automatic test_load_byte_wait();
    op_t o;
    @(negedge clk);
    o = mk(32'h203, 32'h0, 3'b000, 1'b1, 1'b1, 1'b0);
    o.rd = 5'd7;
    drive(o);
    i_dbus_ack = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      i_dbus_ack = 1'b0;
      i_dbus_rdata = $urandom;
      drive(rand_op());  // upstream must be held off; these must not be captured
      #1;
      chk_cnt++;
      if ({o_stall, o_reg_write, o_dbus_req, o_alu_result} !== {1'b1, 1'b0, 1'b1, 32'h203})
        $display("FAIL lb_wait%0d got=%h exp=%h", k, {o_stall, o_reg_write, o_dbus_req, o_alu_result},
                 {1'b1, 1'b0, 1'b1, 32'h203});
      else pass_cnt++;
      tick();
    end
    i_dbus_ack = 1'b1;
    i_dbus_rdata = 32'h8000_0000;
    drive('0);
    #1;
    chk_cnt++;
    if ({o_load_data, o_reg_write, o_stall, o_rd} !== {32'hFFFF_FF80, 1'b1, 1'b0, 5'd7})
      $display("FAIL lb_ack got=%h exp=%h", {o_load_data, o_reg_write, o_stall, o_rd},
               {32'hFFFF_FF80, 1'b1, 1'b0, 5'd7});
    else pass_cnt++;
    tick();
    i_dbus_ack = 1'b0;
  endtask

  task automatic test_lhu_then_sb();
    op_t o;
    o = mk(32'h202, 32'h0, 3'b101, 1'b1, 1'b1, 1'b0);
    drive(o);
    tick();
    i_dbus_ack = 1'b1;
    i_dbus_rdata = 32'h8001_5A5A;
    drive(mk(32'h3, 32'h1234_56AB, 3'b000, 1'b0, 1'b0, 1'b1));
    #1;
    chk_cnt++;
    if ({o_load_data, o_reg_write, o_stall} !== {32'h0000_8001, 1'b1, 1'b0})
      $display("FAIL lhu_data got=%h exp=%h", {o_load_data, o_reg_write, o_stall},
               {32'h0000_8001, 1'b1, 1'b0});
    else pass_cnt++;
    tick();
    drive('0);
    #1;
    chk_cnt++;
    if ({o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_be, o_dbus_wdata} !==
        {1'b1, 1'b1, 30'h0, 4'b1000, 32'hABAB_ABAB})
      $display("FAIL sb_lanes got=%h exp=%h", {o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_be, o_dbus_wdata},
               {1'b1, 1'b1, 30'h0, 4'b1000, 32'hABAB_ABAB});
    else pass_cnt++;
    tick();
    i_dbus_ack = 1'b0;
  endtask

  task automatic test_misaligned();
    drive(mk(32'h102, 32'h0, 3'b010, 1'b1, 1'b1, 1'b0));
    tick();
    drive('0);
    #1;
    chk_cnt++;
    if ({o_misaligned, o_dbus_req, o_reg_write, o_stall} !== 4'b1000)
      $display("FAIL lw_misaligned got=%b exp=1000", {o_misaligned, o_dbus_req, o_reg_write, o_stall});
    else pass_cnt++;
    tick();
    #1;
    chk_cnt++;
    if ({o_misaligned, o_dbus_req} !== 2'b00)
      $display("FAIL misaligned_clear got=%b exp=00", {o_misaligned, o_dbus_req});
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    drive(mk(32'h10, 32'h0, 3'b010, 1'b1, 1'b1, 1'b0));
    i_dbus_ack = 1'b0;
    tick();
    drive('0);
    for (int k = 1; k <= TO; k++) begin
      #1;
      chk_cnt++;
      if (k < TO) begin
        if ({o_bus_err, o_stall, o_dbus_req, o_reg_write} !== 4'b0110)
          $display("FAIL timeout_wait%0d got=%b exp=0110", k, {o_bus_err, o_stall, o_dbus_req, o_reg_write});
        else pass_cnt++;
      end else begin
        if ({o_bus_err, o_stall, o_dbus_req, o_reg_write} !== 4'b1000)
          $display("FAIL timeout_abort got=%b exp=1000", {o_bus_err, o_stall, o_dbus_req, o_reg_write});
        else pass_cnt++;
      end
      tick();
    end
    #1;
    chk_cnt++;
    if ({o_bus_err, o_stall, o_dbus_req} !== 3'b000)
      $display("FAIL timeout_after got=%b exp=000", {o_bus_err, o_stall, o_dbus_req});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_req();
    op_t o;
    o = mk(32'h40, 32'h0, 3'b010, 1'b1, 1'b1, 1'b0);
    o.rd = 5'd3;
    drive(o);
    i_dbus_ack = 1'b0;
    tick();
    #1;
    chk_cnt++;
    if ({o_dbus_req, o_stall} !== 2'b11) $display("FAIL rst_pre_req got=%b exp=11", {o_dbus_req, o_stall});
    else pass_cnt++;
    i_reset = 1'b1;
    drive(rand_op());
    i_mem_read = 1'b1;
    i_reg_write = 1'b1;
    tick();
    #1;
    chk_cnt++;
    if (all_out !== '0) $display("FAIL rst_mid_outputs got=%h exp=0", all_out);
    else pass_cnt++;
    i_dbus_ack = 1'b1;
    i_dbus_rdata = 32'hCAFE_F00D;
    #1;
    chk_cnt++;
    if (all_out !== '0) $display("FAIL rst_stray_ack got=%h exp=0", all_out);
    else pass_cnt++;
    i_reset = 1'b0;
    drive('0);
    tick();
    #1;
    chk_cnt++;
    if (all_out !== '0) $display("FAIL rst_late_ack got=%h exp=0", all_out);
    else pass_cnt++;
    i_dbus_ack = 1'b0;
  endtask

  // Every op is presented in the completing cycle of the previous one.
  task automatic test_random_back_to_back();
    op_t cur;
    op_t nxt;
    int  waits;
    logic [31:0] rdata;
    logic is_mem;
    @(negedge clk);
    cur = rand_op();
    drive(cur);
    i_dbus_ack = 1'b0;
    tick();
    for (int i = 0; i < 60; i++) begin
      nxt = (i == 59) ? op_t'('0) : rand_op();
      is_mem = (cur.mr || cur.mw) && !ref_mis(cur);
      waits = is_mem ? $urandom_range(0, 2) : 0;
      for (int k = 0; k <= waits; k++) begin
        rdata = $urandom;
        i_dbus_rdata = rdata;
        if (k == waits) begin
          i_dbus_ack = is_mem ? 1'b1 : 1'($urandom_range(0, 1));
          drive(nxt);
        end else begin
          i_dbus_ack = 1'b0;
          drive(rand_op());
        end
        #1;
        chk_cnt++;
        if ({o_alu_result, o_rd, o_pc_p4, o_res_src} !== {cur.addr, cur.rd, cur.pc, cur.rsrc})
          $display("FAIL rnd%0d_passthru got=%h exp=%h", i, {o_alu_result, o_rd, o_pc_p4, o_res_src},
                   {cur.addr, cur.rd, cur.pc, cur.rsrc});
        else pass_cnt++;
        chk_cnt++;
        if ({o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_be} !==
            {is_mem, is_mem & cur.mw, cur.addr[31:2], is_mem ? ref_be(cur) : 4'h0})
          $display("FAIL rnd%0d_bus got=%h exp=%h", i, {o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_be},
                   {is_mem, is_mem & cur.mw, cur.addr[31:2], is_mem ? ref_be(cur) : 4'h0});
        else pass_cnt++;
        chk_cnt++;
        if ({o_stall, o_reg_write, o_misaligned, o_bus_err} !==
            {k < waits, (k == waits) && cur.rw && !ref_mis(cur), ref_mis(cur), 1'b0})
          $display("FAIL rnd%0d_ctrl got=%b exp=%b", i, {o_stall, o_reg_write, o_misaligned, o_bus_err},
                   {k < waits, (k == waits) && cur.rw && !ref_mis(cur), ref_mis(cur), 1'b0});
        else pass_cnt++;
        if (is_mem && cur.mw) begin
          chk_cnt++;
          if (o_dbus_wdata !== ref_wdata(cur))
            $display("FAIL rnd%0d_wdata got=%h exp=%h", i, o_dbus_wdata, ref_wdata(cur));
          else pass_cnt++;
        end
        if (is_mem && cur.mr && !cur.mw && (k == waits)) begin
          chk_cnt++;
          if (o_load_data !== ref_load(cur, rdata))
            $display("FAIL rnd%0d_load got=%h exp=%h", i, o_load_data, ref_load(cur, rdata));
          else pass_cnt++;
        end
        tick();
      end
      cur = nxt;
    end
    i_dbus_ack = 1'b0;
  endtask

  initial begin
    i_dbus_ack   = 1'b0;
    i_dbus_rdata = '0;
    test_reset();
    test_store_word();
    test_load_byte_wait();
    test_lhu_then_sb();
    test_misaligned();
    test_timeout();
    test_reset_mid_req();
    test_random_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
